instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 19 +
 rtl/instr_fetch_fetch_fifo.sv | 45 ++++
 rtl/instr_fetch.sv | 88 ++++++++
 tb/tb_instr_fetch.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared CPU fetch constants: FSM encodings, NOP word, PC stride and the
// {pc, instr} record carried through the fetch FIFO.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fetch_fifo.sv
// Two-entry {pc, instr} queue between imem and decode. Flush beats push/pop;
// push+pop in one cycle is legal whenever the queue holds something.
module fetch_fifo
  import instr_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push, do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign do_pop  = pop_i && !empty_o;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem request, 2-deep prefetch queue,
// redirect flushes the queue and drains any in-flight response.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic         push, pop, room, issue;
  logic         fifo_full, fifo_empty;
  fetch_entry_t head;
  logic         redirect_lsb_unused;

  assign redirect_lsb_unused = &{1'b0, redirect_pc[1:0]};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    pop  = !fifo_empty && !stall && !redirect;
    push = (state_q == WAIT) && imem_ack && !redirect;
    // Room means post-push/pop occupancy stays below two.
    room  = push ? (pop ? !fifo_full : fifo_empty) : (pop || !fifo_full);
    issue = !redirect && ((state_q == FETCH) || push) && room;
    unique case (state_q)
      FETCH: ;
      WAIT: begin
        if (redirect)                  state_d = imem_ack ? FETCH : DRAIN;
        else if (imem_ack && !issue)   state_d = FETCH;
      end
      DRAIN: if (imem_ack) state_d = FETCH;
      default: state_d = FETCH;
    endcase
    if (redirect) fetch_pc_d = {redirect_pc[31:2], 2'b00};
    if (issue) begin
      state_d    = WAIT;
      req_addr_d = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  fetch_fifo u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i ('{pc: req_addr_q, instr: imem_rdata}),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign imem_req    = issue && !reset;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = !fifo_empty;
  assign instr       = instr_valid ? head.instr : NOP_WORD;
  assign instr_pc    = instr_valid ? head.pc    : NOP_WORD;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed cycle table, then a random-latency memory
// with a scoreboard of expected {pc, instr} pairs.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_ack, redirect, stall, instr_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

  typedef struct {
    logic        rst, ack;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        stl;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evld;
    logic [31:0] einstr, epc;
  } vec_t;

  typedef struct {
    logic [31:0] pc, instr;
  } exp_t;

  vec_t vt[$];
  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(logic rst, logic ack, logic [31:0] rdata, logic redir,
                              logic [31:0] rpc, logic stl, logic ereq, logic [31:0] eaddr,
                              logic evld, logic [31:0] einstr, logic [31:0] epc);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.redir = redir; v.rpc = rpc; v.stl = stl;
    v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.einstr = einstr; v.epc = epc;
    return v;
  endfunction

  localparam logic [31:0] I  = 32'h0050_0093;
  localparam logic [31:0] DA = 32'hA000_010C, DB = 32'hB000_0110, DC = 32'hC000_0114;
  localparam logic [31:0] DE = 32'hE000_0200, DF = 32'hF000_FFFC, DG = 32'h6000_0000;
  localparam logic [31:0] DH = 32'h7000_0100, DK = 32'h8000_040C;

  initial begin
    logic        out_vld;
    logic [31:0] out_addr, mpc, rd;
    int          out_cnt, pops;
    exp_t        e;

    //               rst ack rdata          rdr rpc            stl  req addr           vld instr pc
    vt.push_back(mk(1, 0, 0,             0, 0,             0,   0, 0,             0, 0,  0));            // r0 reset state
    vt.push_back(mk(0, 0, 0,             0, 0,             0,   1, 32'h100,       0, 0,  0));            // r1 first fetch
    vt.push_back(mk(0, 1, I,             0, 0,             0,   1, 32'h104,       0, 0,  0));
    vt.push_back(mk(0, 1, I,             0, 0,             0,   1, 32'h108,       1, I,  32'h100));
    vt.push_back(mk(0, 1, I,             0, 0,             0,   1, 32'h10C,       1, I,  32'h104));
    vt.push_back(mk(0, 1, DA,            0, 0,             1,   0, 0,             1, I,  32'h108));      // r5 stall fills FIFO
    vt.push_back(mk(0, 0, 0,             0, 0,             1,   0, 0,             1, I,  32'h108));
    vt.push_back(mk(0, 0, 0,             0, 0,             1,   0, 0,             1, I,  32'h108));
    vt.push_back(mk(0, 0, 0,             0, 0,             1,   0, 0,             1, I,  32'h108));
    vt.push_back(mk(0, 0, 0,             0, 0,             0,   1, 32'h110,       1, I,  32'h108));      // r9 release
    vt.push_back(mk(0, 1, DB,            0, 0,             0,   1, 32'h114,       1, DA, 32'h10C));
    vt.push_back(mk(0, 0, 0,             0, 0,             0,   0, 0,             1, DB, 32'h110));
    vt.push_back(mk(0, 1, DC,            0, 0,             0,   1, 32'h118,       0, 0,  0));
    vt.push_back(mk(0, 0, 0,             1, 32'h203,       0,   0, 0,             1, DC, 32'h114));      // r13 redirect, req outstanding
    vt.push_back(mk(0, 1, 32'hDEAD_BEEF, 0, 0,             0,   0, 0,             0, 0,  0));            // late ack dropped
    vt.push_back(mk(0, 0, 0,             0, 0,             0,   1, 32'h200,       0, 0,  0));
    vt.push_back(mk(0, 1, DE,            0, 0,             0,   1, 32'h204,       0, 0,  0));
    vt.push_back(mk(0, 0, 0,             0, 0,             1,   0, 0,             1, DE, 32'h200));
    vt.push_back(mk(0, 1, 32'hBAD0_0001, 1, 32'hFFFF_FFFC, 0,   0, 0,             1, DE, 32'h200));      // r18 redirect+ack
    vt.push_back(mk(0, 0, 0,             0, 0,             0,   1, 32'hFFFF_FFFC, 0, 0,  0));
    vt.push_back(mk(0, 1, DF,            0, 0,             0,   1, 32'h0,         0, 0,  0));            // PC wrap
    vt.push_back(mk(0, 1, DG,            0, 0,             0,   1, 32'h4,         1, DF, 32'hFFFF_FFFC));
    vt.push_back(mk(0, 0, 0,             0, 0,             0,   0, 0,             1, DG, 32'h0));
    vt.push_back(mk(1, 0, 0,             0, 0,             0,   0, 0,             0, 0,  0));            // r23 reset in WAIT
    vt.push_back(mk(0, 1, 32'hBAD0_0002, 0, 0,             0,   1, 32'h100,       0, 0,  0));            // stale ack ignored
    vt.push_back(mk(0, 0, 0,             0, 0,             0,   0, 0,             0, 0,  0));
    vt.push_back(mk(0, 1, DH,            0, 0,             0,   1, 32'h104,       0, 0,  0));
    vt.push_back(mk(0, 0, 0,             0, 0,             0,   0, 0,             1, DH, 32'h100));
    vt.push_back(mk(0, 0, 0,             1, 32'h300,       0,   0, 0,             0, 0,  0));            // r28 -> DRAIN
    vt.push_back(mk(0, 0, 0,             1, 32'h40D,       0,   0, 0,             0, 0,  0));            // redirect in DRAIN
    vt.push_back(mk(0, 1, 32'hBAD0_0003, 0, 0,             0,   0, 0,             0, 0,  0));
    vt.push_back(mk(0, 0, 0,             0, 0,             0,   1, 32'h40C,       0, 0,  0));
    vt.push_back(mk(0, 1, DK,            0, 0,             0,   1, 32'h410,       0, 0,  0));
    vt.push_back(mk(0, 0, 0,             0, 0,             0,   0, 0,             1, DK, 32'h40C));

    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vt[i]) begin
      @(negedge clk);
      reset = vt[i].rst; imem_ack = vt[i].ack; imem_rdata = vt[i].rdata;
      redirect = vt[i].redir; redirect_pc = vt[i].rpc; stall = vt[i].stl;
      #1;
      n_vec++;
      if ((imem_req !== vt[i].ereq) || (vt[i].ereq && (imem_addr !== vt[i].eaddr)) ||
          (instr_valid !== vt[i].evld) || (instr !== vt[i].einstr) || (instr_pc !== vt[i].epc)) begin
        n_miss++;
        $display("FAIL vec%0d: got req=%b addr=%h vld=%b instr=%h pc=%h, want req=%b addr=%h vld=%b instr=%h pc=%h",
                 i, imem_req, imem_addr, instr_valid, instr, instr_pc,
                 vt[i].ereq, vt[i].eaddr, vt[i].evld, vt[i].einstr, vt[i].epc);
      end
    end

    // Random-latency memory with random decode stalls, checked by scoreboard.
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b0; redirect = 1'b0; stall = 1'b0;
    out_vld = 1'b0; out_addr = '0; out_cnt = 0; mpc = 32'h100; pops = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      reset = 1'b0;
      stall = ($urandom_range(0, 3) == 0);
      imem_ack = 1'b0;
      rd = $urandom;
      imem_rdata = rd;
      if (out_vld && out_cnt == 0) imem_ack = 1'b1;
      else if (out_vld) out_cnt--;
      #1;
      if (!instr_valid && ((instr !== 32'h0) || (instr_pc !== 32'h0))) begin
        n_vec++; n_miss++;
        $display("FAIL nop_when_invalid: got instr=%h pc=%h, want 0/0", instr, instr_pc);
      end
      if (instr_valid && !stall) begin
        n_vec++; pops++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL sb_pop: got pc=%h instr=%h, want nothing pending", instr_pc, instr);
        end else begin
          e = exp_q.pop_front();
          if ((instr_pc !== e.pc) || (instr !== e.instr)) begin
            n_miss++;
            $display("FAIL sb_pop: got pc=%h instr=%h, want pc=%h instr=%h", instr_pc, instr, e.pc, e.instr);
          end
        end
      end
      if (imem_req) begin
        n_vec++;
        if ((out_vld && !imem_ack) || (imem_addr !== mpc)) begin
          n_miss++;
          $display("FAIL sb_req: got addr=%h outstanding=%b, want addr=%h with none outstanding",
                   imem_addr, out_vld && !imem_ack, mpc);
        end
        mpc = mpc + 32'd4;
      end
      if (imem_ack) begin
        e.pc = out_addr; e.instr = rd;
        exp_q.push_back(e);
        out_vld = 1'b0;
      end
      if (imem_req) begin
        out_vld = 1'b1; out_addr = imem_addr; out_cnt = $urandom_range(0, 2);
      end
    end
    n_vec++;
    if (pops < 50) begin
      n_miss++;
      $display("FAIL sb_progress: got %0d pops, want at least 50", pops);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
